// File: rtl/aes_pkg.sv
// Shared AES-128 types plus GF(2^8) arithmetic for the iterative decryptor.
// S-boxes are computed by field inversion plus affine map instead of 256-entry tables.
package aes_pkg;

    typedef logic [0:3][0:3][7:0] state_t;   // [row][col] byte, col c = key word c

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse; zero maps to zero as AES requires
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        logic [7:0] s;
        b = ginv(a);
        s = '0;
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++)
            b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8];
        return ginv(b ^ 8'h05);
    endfunction

    // rcon(i) is the constant used to derive round key i+1
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// Ciphertext/key input and plaintext output handshakes of the iterative AES decryptor.
interface aes_decrypt_iter_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t ct;
    state_t key;
    logic   out_valid;
    logic   out_ready;
    state_t pt;
    logic   busy;

    modport slave  (input  in_valid, ct, key, out_ready,
                    output in_ready, out_valid, pt, busy);
    modport master (output in_valid, ct, key, out_ready,
                    input  in_ready, out_valid, pt, busy);
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last_i is set.
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t s_i,
    input  state_t rk_i,
    input  logic   last_i,
    output state_t s_o
);

    localparam logic [0:3][7:0] IMC = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    state_t ark;

    always_comb begin
        ark = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ark[r][c] = inv_sbox(s_i[r][(c + 4 - r) % 4]) ^ rk_i[r][c];

        s_o = ark;
        if (!last_i) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    s_o[r][c] = 8'h00;
                    for (int k = 0; k < 4; k++)
                        s_o[r][c] = s_o[r][c] ^ gmul(IMC[(k + 4 - r) % 4], ark[k][c]);
                end
        end
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor, one round per clock; out_valid 21 cycles after accept (11 on a key-cache hit).
// Accepts only in IDLE; holds pt/out_valid in DONE until out_ready.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter bit KEY_CACHE = 1'b1
)
(
    input  logic               clk,
    input  logic               rst_n,
    aes_decrypt_iter_if.slave  io
);

    fsm_e       fsm_q, fsm_d;
    state_t     st_q, st_d;
    state_t     rk_q, rk_d;
    state_t     pt_q, pt_d;
    state_t     ck_key_q, ck_key_d;
    state_t     ck_rk_q, ck_rk_d;
    logic       ck_vld_q, ck_vld_d;
    logic       ov_q, ov_d;
    logic [3:0] cnt_q, cnt_d;

    state_t     rk_fwd, rk_rev, round_out;
    logic       accept, hit;

    function automatic state_t key_fwd(input state_t k, input logic [7:0] rc);
        state_t n;
        for (int r = 0; r < 4; r++)
            n[r][0] = k[r][0] ^ sbox(k[(r + 1) % 4][3]) ^ ((r == 0) ? rc : 8'h00);
        for (int c = 1; c < 4; c++)
            for (int r = 0; r < 4; r++)
                n[r][c] = k[r][c] ^ n[r][c - 1];
        return n;
    endfunction

    function automatic state_t key_rev(input state_t k, input logic [7:0] rc);
        state_t n;
        for (int c = 1; c < 4; c++)
            for (int r = 0; r < 4; r++)
                n[r][c] = k[r][c] ^ k[r][c - 1];
        for (int r = 0; r < 4; r++)
            n[r][0] = k[r][0] ^ sbox(n[(r + 1) % 4][3]) ^ ((r == 0) ? rc : 8'h00);
        return n;
    endfunction

    // cnt_q is the key index being built in KEYEXP and the round number r in ROUND
    assign rk_fwd = key_fwd(rk_q, rcon(cnt_q));
    assign rk_rev = key_rev(rk_q, rcon(cnt_q));
    assign accept = io.in_valid && (fsm_q == IDLE);
    assign hit    = KEY_CACHE && ck_vld_q && (io.key == ck_key_q);

    aes_inv_round u_round (
        .s_i    (st_q),
        .rk_i   (rk_rev),
        .last_i (cnt_q == 4'd0),
        .s_o    (round_out)
    );

    always_comb begin
        fsm_d    = fsm_q;
        st_d     = st_q;
        rk_d     = rk_q;
        pt_d     = pt_q;
        ck_key_d = ck_key_q;
        ck_rk_d  = ck_rk_q;
        ck_vld_d = ck_vld_q;
        ov_d     = ov_q;
        cnt_d    = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        st_d  = io.ct ^ ck_rk_q;
                        rk_d  = ck_rk_q;
                        cnt_d = 4'd9;
                        fsm_d = ROUND;
                    end else begin
                        st_d     = io.ct;
                        rk_d     = io.key;
                        cnt_d    = 4'd0;
                        ck_vld_d = 1'b0;
                        ck_key_d = io.key;
                        fsm_d    = KEYEXP;
                    end
                end
            end
            KEYEXP: begin
                rk_d  = rk_fwd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    st_d     = st_q ^ rk_fwd;
                    ck_rk_d  = rk_fwd;
                    ck_vld_d = KEY_CACHE;
                    cnt_d    = 4'd9;
                    fsm_d    = ROUND;
                end
            end
            ROUND: begin
                st_d  = round_out;
                rk_d  = rk_rev;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    cnt_d = 4'd0;
                    fsm_d = DONE;
                end
            end
            DONE: begin
                // first DONE cycle moves the result into the separate output register
                if (!ov_q) begin
                    pt_d = st_q;
                    ov_d = 1'b1;
                end else if (io.out_ready) begin
                    ov_d  = 1'b0;
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            st_q     <= '0;
            rk_q     <= '0;
            pt_q     <= '0;
            ck_key_q <= '0;
            ck_rk_q  <= '0;
            ck_vld_q <= 1'b0;
            ov_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            fsm_q    <= fsm_d;
            st_q     <= st_d;
            rk_q     <= rk_d;
            pt_q     <= pt_d;
            ck_key_q <= ck_key_d;
            ck_rk_q  <= ck_rk_d;
            ck_vld_q <= ck_vld_d;
            ov_q     <= ov_d;
            cnt_q    <= cnt_d;
        end
    end

    assign io.in_ready  = (fsm_q == IDLE);
    assign io.out_valid = ov_q;
    assign io.pt        = pt_q;
    assign io.busy      = (fsm_q != IDLE);

endmodule
